// File: rtl/rv_instr_stream_encoder.sv
// RV32I field-bundle encoder: range-checks decoded assembly fields, encodes legal bundles into a
// small FIFO and streams them out with an auto-incrementing byte address for memory preload.
module rv_instr_stream_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int BASE_ADDR  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        restart,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2:0]                  in_fmt,
   input  logic [4:0]                  in_rd,
   input  logic [4:0]                  in_rs1,
   input  logic [4:0]                  in_rs2,
   input  logic [2:0]                  in_funct3,
   input  logic [6:0]                  in_funct7,
   input  logic [31:0]                 in_imm,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [31:0]                 out_instr,
   output logic [ADDR_WIDTH-1:0]       out_addr,
   output logic                        err,
   output logic [2:0]                  err_code,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int PW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  err_q, err_d;
   logic [2:0]            err_code_q, err_code_d;
   logic [31:0]           mem_q [FIFO_DEPTH];
   logic [31:0]           mem_d [FIFO_DEPTH];

   logic [31:0] enc_word;
   logic [2:0]  ill_code;
   logic        imm12_ok, imm13_ok, imm21_ok, is_shift;
   logic        full, accept, push, pop;

   // Signed-range checks: the value fits when every bit above the sign bit matches it.
   assign imm12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
   assign imm13_ok = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
   assign imm21_ok = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
   assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   always_comb begin
      enc_word = 32'h0;
      ill_code = 3'd0;
      case (in_fmt)
         3'd0: begin
            enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            if (!((in_funct7 == 7'h00) ||
                  ((in_funct7 == 7'h20) && ((in_funct3 == 3'b000) || (in_funct3 == 3'b101)))))
               ill_code = 3'd1;
         end
         3'd1: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            if (!imm12_ok)
               ill_code = 3'd2;
            else if (is_shift && !((in_imm[11:5] == 7'h00) ||
                                   ((in_imm[11:5] == 7'h20) && (in_funct3 == 3'b101))))
               ill_code = 3'd3;
         end
         3'd2: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            if (!imm12_ok)
               ill_code = 3'd2;
            else if ((in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111))
               ill_code = 3'd6;
         end
         3'd3: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            if (!imm12_ok)
               ill_code = 3'd2;
            else if (in_funct3 > 3'd2)
               ill_code = 3'd6;
         end
         3'd4: begin
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_BRANCH};
            if (!imm13_ok || in_imm[0])
               ill_code = 3'd4;
         end
         3'd5: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            if (!imm21_ok || in_imm[0])
               ill_code = 3'd4;
         end
         3'd6: begin
            enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            if (!imm12_ok)
               ill_code = 3'd2;
            else if (in_funct3 != 3'b000)
               ill_code = 3'd6;
         end
         3'd7: begin
            enc_word = {in_imm[31:12], in_rd, OP_LUI};
            if (in_imm[11:0] != 12'h000)
               ill_code = 3'd5;
         end
      endcase
   end

   assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
   assign in_ready  = !full;
   assign out_valid = (wr_ptr_q != rd_ptr_q);
   assign level     = wr_ptr_q - rd_ptr_q;
   assign out_instr = mem_q[rd_ptr_q[PW-2:0]];
   assign out_addr  = addr_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

   // Illegal bundles still complete the handshake but never reach the FIFO.
   assign accept = in_valid && in_ready && !restart;
   assign push   = accept && (ill_code == 3'd0);
   assign pop    = out_valid && out_ready && !restart;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      addr_d     = addr_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      mem_d      = mem_q;
      if (restart) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         addr_d     = BASE;
         err_d      = 1'b0;
         err_code_d = 3'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q[PW-2:0]] = enc_word;
            wr_ptr_d                = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + ADDR_WIDTH'(4);
         end
         if (accept && (ill_code != 3'd0)) begin
            err_d = 1'b1;
            if (!err_q)
               err_code_d = ill_code;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         addr_q     <= BASE;
         err_q      <= 1'b0;
         err_code_q <= 3'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_rv_instr_stream_encoder.sv
// Bench for rv_instr_stream_encoder: a queue-based reference model checked every cycle, directed
// scenarios with literal expectations, and a randomized traffic phase.
module tb_rv_instr_stream_encoder;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        restart = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_fmt = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [11:0] out_addr;
   logic        err;
   logic [2:0]  err_code;
   logic [2:0]  level;

   int nPass = 0;
   int nTotal = 0;
   bit checkEn = 1'b0;

   bit [31:0] mq[$];
   int        maddr = 0;
   bit        merr = 1'b0;
   int        mcode = 0;
   int        mpops = 0;

   rv_instr_stream_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(12), .BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .err(err), .err_code(err_code), .level(level)
   );

   initial forever #5 clk = ~clk;

   // Field placement written directly from the RV32I instruction formats.
   function automatic logic [31:0] modelEnc(input int fmt, input int rd, input int rs1,
                                            input int rs2, input int f3, input int f7, input int imm);
      bit [31:0] u;
      bit [31:0] r;
      u = imm;
      r = 0;
      case (fmt)
         0: r = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         1: r = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         2: r = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         3: r = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                | ((u & 32'h1F) << 7) | 32'h23;
         4: r = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                | (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
         5: r = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
         6: r = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
         default: r = (u & 32'hFFFFF000) | (rd << 7) | 32'h37;
      endcase
      return r;
   endfunction

   function automatic int modelCode(input int fmt, input int f3, input int f7, input int imm);
      int hi;
      bit inRange12;
      inRange12 = (imm >= -2048) && (imm <= 2047);
      hi = (imm >> 5) & 32'h7F;
      case (fmt)
         0: return ((f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5))) ? 0 : 1;
         1: begin
            if (!inRange12) return 2;
            if ((f3 == 1 || f3 == 5) && !(hi == 0 || (hi == 32 && f3 == 5))) return 3;
            return 0;
         end
         2: return !inRange12 ? 2 : ((f3 == 3 || f3 == 6 || f3 == 7) ? 6 : 0);
         3: return !inRange12 ? 2 : ((f3 >= 3) ? 6 : 0);
         4: return ((imm & 1) != 0 || imm < -4096 || imm > 4094) ? 4 : 0;
         5: return ((imm & 1) != 0 || imm < -(1 << 20) || imm > (1 << 20) - 2) ? 4 : 0;
         6: return !inRange12 ? 2 : ((f3 != 0) ? 6 : 0);
         default: return ((imm & 32'hFFF) != 0) ? 5 : 0;
      endcase
   endfunction

   // Reference model: advances on every rising edge from the inputs held across it.
   initial forever begin
      @(posedge clk);
      if (reset || restart) begin
         mq.delete();
         maddr = 0;
         merr  = 1'b0;
         mcode = 0;
         mpops = 0;
      end else begin
         bit acc;
         int code;
         acc = in_valid && (mq.size() < DEPTH);
         if (mq.size() > 0 && out_ready) begin
            void'(mq.pop_front());
            maddr = (maddr + 4) % 4096;
            mpops++;
         end
         if (acc) begin
            code = modelCode(int'(in_fmt), int'(in_funct3), int'(in_funct7), int'(in_imm));
            if (code == 0)
               mq.push_back(modelEnc(int'(in_fmt), int'(in_rd), int'(in_rs1), int'(in_rs2),
                                     int'(in_funct3), int'(in_funct7), int'(in_imm)));
            else begin
               if (!merr) mcode = code;
               merr = 1'b1;
            end
         end
      end
   end

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic checkOutput();
      checkEq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      checkEq("level", 32'(level), 32'(mq.size()));
      checkEq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      checkEq("err", 32'(err), 32'(merr));
      checkEq("err_code", 32'(err_code), 32'(mcode));
      checkEq("out_addr", 32'(out_addr), 32'(maddr));
      if (mq.size() != 0) checkEq("out_instr", out_instr, mq[0]);
   endtask

   initial forever begin
      @(negedge clk);
      if (checkEn) checkOutput();
   end

   task automatic applyStimulus(input int v, input int ordy, input int rst, input int fmt,
                                input int rd, input int rs1, input int rs2, input int f3,
                                input int f7, input int imm);
      in_valid  = v[0];
      out_ready = ordy[0];
      restart   = rst[0];
      in_fmt    = 3'(fmt);
      in_rd     = 5'(rd);
      in_rs1    = 5'(rs1);
      in_rs2    = 5'(rs2);
      in_funct3 = 3'(f3);
      in_funct7 = 7'(f7);
      in_imm    = 32'(imm);
      @(negedge clk);
   endtask

   task automatic idle(input int ordy);
      applyStimulus(0, ordy, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic int genImm(input int fmt);
      int r;
      r = $urandom_range(0, 11);
      if (fmt == 7) return (r < 9) ? int'($urandom & 32'hFFFFF000) : int'($urandom);
      if (fmt == 1 && r < 3) return ($urandom_range(0, 1) ? 32'h400 : 0) | $urandom_range(0, 31);
      case (r)
         0: return int'($urandom);
         1: return 2047;
         2: return -2048;
         3: return 2048;
         4: return -4096;
         5: return 4094;
         6: return (1 << 20) - 2;
         7: return -(1 << 20);
         default: return int'($urandom_range(0, 4095)) - 2048;
      endcase
   endfunction

   initial begin
      int budget;
      repeat (3) @(negedge clk);
      reset   = 1'b0;
      checkEn = 1'b1;

      idle(0);
      checkEq("rst_out_valid", 32'(out_valid), 32'd0);
      checkEq("rst_level", 32'(level), 32'd0);
      checkEq("rst_in_ready", 32'(in_ready), 32'd1);
      checkEq("rst_out_addr", 32'(out_addr), 32'd0);
      checkEq("rst_err", 32'(err), 32'd0);

      checkEq("model_add", modelEnc(0, 3, 1, 2, 0, 0, 0), 32'h002081B3);
      checkEq("model_sub", modelEnc(0, 5, 6, 7, 0, 32, 0), 32'h407302B3);
      checkEq("model_addi", modelEnc(1, 1, 0, 0, 0, 0, -1), 32'hFFF00093);
      checkEq("model_lui", modelEnc(7, 2, 0, 0, 0, 0, 32'h12345000), 32'h12345137);
      checkEq("model_beq", modelEnc(4, 0, 1, 2, 0, 0, -8), 32'hFE208CE3);
      checkEq("model_jal", modelEnc(5, 1, 0, 0, 0, 0, 2048), 32'h001000EF);
      checkEq("model_code2", 32'(modelCode(1, 0, 0, 2048)), 32'd2);

      applyStimulus(1, 0, 0, 0, 3, 1, 2, 0, 0, 0);
      checkEq("latency_valid", 32'(out_valid), 32'd1);
      applyStimulus(1, 0, 0, 0, 5, 6, 7, 0, 32, 0);
      checkEq("add_word", out_instr, 32'h002081B3);
      checkEq("add_addr", 32'(out_addr), 32'h000);
      idle(1);
      checkEq("sub_word", out_instr, 32'h407302B3);
      checkEq("sub_addr", 32'(out_addr), 32'h004);

      applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, 2048);
      checkEq("ill_err", 32'(err), 32'd1);
      checkEq("ill_code", 32'(err_code), 32'd2);
      checkEq("ill_level", 32'(level), 32'd1);
      applyStimulus(1, 0, 0, 0, 1, 1, 1, 0, 1, 0);
      checkEq("ill2_code", 32'(err_code), 32'd2);
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, -1);
      idle(1);
      checkEq("addi_word", out_instr, 32'hFFF00093);
      checkEq("addi_addr", 32'(out_addr), 32'h008);
      idle(1);

      applyStimulus(1, 0, 0, 7, 2, 0, 0, 0, 0, 32'h12345000);
      applyStimulus(1, 0, 0, 4, 0, 1, 2, 0, 0, -8);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 2048);
      checkEq("lui_word", out_instr, 32'h12345137);
      idle(1);
      checkEq("beq_word", out_instr, 32'hFE208CE3);
      idle(1);
      checkEq("jal_word", out_instr, 32'h001000EF);
      idle(1);

      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, i);
      checkEq("full_in_ready", 32'(in_ready), 32'd0);
      checkEq("full_level", 32'(level), 32'(DEPTH));
      applyStimulus(1, 1, 0, 1, 2, 0, 0, 0, 0, 7);
      checkEq("pop_full_level", 32'(level), 32'(DEPTH - 1));
      applyStimulus(1, 0, 0, 1, 2, 0, 0, 0, 0, 7);
      checkEq("push_after_level", 32'(level), 32'(DEPTH));
      idle(1);
      checkEq("pre_restart_level", 32'(level), 32'd3);
      checkEq("pre_restart_err", 32'(err), 32'd1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkEq("restart_level", 32'(level), 32'd0);
      checkEq("restart_valid", 32'(out_valid), 32'd0);
      checkEq("restart_addr", 32'(out_addr), 32'd0);
      checkEq("restart_err", 32'(err), 32'd0);

      budget = 0;
      while (mpops < 1023 && budget < 1200) begin
         applyStimulus(1, 1, 0, 7, budget % 32, 0, 0, 0, 0, budget << 12);
         budget++;
      end
      checkEq("wrap_budget", 32'(mpops), 32'd1023);
      checkEq("wrap_pre_addr", 32'(out_addr), 32'hFFC);
      applyStimulus(1, 1, 0, 7, 3, 0, 0, 0, 0, 32'h00001000);
      checkEq("wrap_post_addr", 32'(out_addr), 32'h000);
      checkEq("wrap_post_valid", 32'(out_valid), 32'd1);

      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 800; i++) begin
         int fmt, f7sel, f7;
         fmt   = $urandom_range(0, 7);
         f7sel = $urandom_range(0, 5);
         f7    = (f7sel < 3) ? 0 : ((f7sel < 5) ? 32 : int'($urandom_range(0, 127)));
         applyStimulus(($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 9) < 6) ? 1 : 0,
                       ($urandom_range(0, 39) == 0) ? 1 : 0, fmt,
                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 7), f7, genImm(fmt));
      end
      repeat (DEPTH + 1) idle(1);

      checkEn = 1'b0;
      $display("[TB] %0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
